alu_cmd_issuer: RTL and testbench

// - Upstream command stage for the ALU: buffers operation commands in a FIFO and issues them one at a time.
// - Drives start/op/A/B/sv/op_prefix, holds them stable until done, then captures result/err/gp.
// - Returns each response on a valid/ready channel; only one ALU operation is in flight at a time.

---
 rtl/alu_cmd_issuer.sv | 226 ++++++++++++++++++++++
 tb/tb_alu_cmd_issuer.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_issuer.sv
// rtl/alu_cmd_issuer.sv - command FIFO and single-outstanding issuer in front of the ALU
//
// Purpose:
//   Buffers ALU commands in a DEPTH-entry FIFO and issues them one at a time.
//   While an operation is in flight, the alu_* outputs are held stable.
//   The result, error code and gp flag are captured when alu_done arrives.
//   Each answer is returned on a valid/ready response channel, in command order.
//   Opcodes above 10 are answered directly with err 8'hEE and never reach the ALU.
//
// Optional feature (macro ALU_ISSUE_TIMEOUT_EN):
//   When defined, a command that stays BUSY for TIMEOUT_CYCLES cycles without
//   alu_done is aborted and answered with err 8'hFF. If alu_done arrives on the
//   same edge as the timeout, the normal capture wins.
//
// Ports:
//   clk, reset_n                       clock; synchronous active-low reset
//   cmd_valid/cmd_ready                command push handshake
//   cmd_op/cmd_a/cmd_b/cmd_sv/cmd_op_prefix
//                                      command payload
//   alu_start, alu_op, alu_a, alu_b, alu_sv, alu_op_prefix
//                                      registered request to the ALU
//   alu_done, alu_result, alu_err, alu_gp
//                                      ALU completion and status
//   rsp_valid/rsp_ready                response handshake
//   rsp_op/rsp_result/rsp_err/rsp_gp   response payload
//   fifo_count                         FIFO occupancy
module alu_cmd_issuer #(
  parameter int DEPTH          = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [7:0]                 cmd_op,
  input  logic [31:0]                cmd_a,
  input  logic [31:0]                cmd_b,
  input  logic                       cmd_sv,
  input  logic                       cmd_op_prefix,
  output logic                       alu_start,
  output logic [7:0]                 alu_op,
  output logic [31:0]                alu_a,
  output logic [31:0]                alu_b,
  output logic                       alu_sv,
  output logic                       alu_op_prefix,
  input  logic                       alu_done,
  input  logic [63:0]                alu_result,
  input  logic [7:0]                 alu_err,
  input  logic                       alu_gp,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [7:0]                 rsp_op,
  output logic [63:0]                rsp_result,
  output logic [7:0]                 rsp_err,
  output logic                       rsp_gp,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  typedef struct packed {
    logic [7:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        sv;
    logic        prefix;
  } cmd_t;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

  // ---------------- command FIFO ----------------
  cmd_t          mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push, pop;
  cmd_t          cmd_in, head;
  state_t        state_q;

  assign cmd_in     = {cmd_op, cmd_a, cmd_b, cmd_sv, cmd_op_prefix};
  assign head       = mem_q[rd_ptr_q];
  // Ready comes from the registered count only, so a pop in the same cycle
  // never opens a slot for a push into a full FIFO.
  assign cmd_ready  = (count_q != CW'(DEPTH));
  assign push       = cmd_valid && cmd_ready;
  assign pop        = (state_q == S_IDLE) && (count_q != '0);
  assign fifo_count = count_q;

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: an entry is only read after it was written.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= cmd_in;
  end

  // ---------------- issue / response FSM ----------------
  logic        alu_start_q;
  logic [7:0]  alu_op_q;
  logic [31:0] alu_a_q, alu_b_q;
  logic        alu_sv_q, alu_prefix_q;
  logic        rsp_valid_q;
  logic [7:0]  rsp_op_q, rsp_err_q;
  logic [63:0] rsp_result_q;
  logic        rsp_gp_q;

`ifdef ALU_ISSUE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt_q;
`else
  logic tmo_param_unused;
  assign tmo_param_unused = (TIMEOUT_CYCLES != 0);
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      alu_start_q  <= 1'b0;
      alu_op_q     <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_sv_q     <= 1'b0;
      alu_prefix_q <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_op_q     <= '0;
      rsp_result_q <= '0;
      rsp_err_q    <= '0;
      rsp_gp_q     <= 1'b0;
`ifdef ALU_ISSUE_TIMEOUT_EN
      tmo_cnt_q    <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (count_q != '0) begin
            if (head.op <= 8'd10) begin
              alu_op_q     <= head.op;
              alu_a_q      <= head.a;
              alu_b_q      <= head.b;
              alu_sv_q     <= head.sv;
              alu_prefix_q <= head.prefix;
              alu_start_q  <= 1'b1;
              state_q      <= S_BUSY;
`ifdef ALU_ISSUE_TIMEOUT_EN
              tmo_cnt_q    <= '0;
`endif
            end else begin
              // Unknown opcode: answered locally, the ALU never sees it.
              rsp_op_q     <= head.op;
              rsp_result_q <= '0;
              rsp_err_q    <= 8'hEE;
              rsp_gp_q     <= 1'b0;
              rsp_valid_q  <= 1'b1;
              state_q      <= S_RESP;
            end
          end
        end
        S_BUSY: begin
          if (alu_done) begin
            rsp_op_q     <= alu_op_q;
            rsp_result_q <= alu_result;
            rsp_err_q    <= alu_err;
            rsp_gp_q     <= alu_gp;
            rsp_valid_q  <= 1'b1;
            alu_start_q  <= 1'b0;
            state_q      <= S_RESP;
          end
`ifdef ALU_ISSUE_TIMEOUT_EN
          else if (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
            rsp_op_q     <= alu_op_q;
            rsp_result_q <= '0;
            rsp_err_q    <= 8'hFF;
            rsp_gp_q     <= 1'b0;
            rsp_valid_q  <= 1'b1;
            alu_start_q  <= 1'b0;
            state_q      <= S_RESP;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + TW'(1);
          end
`endif
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign alu_start     = alu_start_q;
  assign alu_op        = alu_op_q;
  assign alu_a         = alu_a_q;
  assign alu_b         = alu_b_q;
  assign alu_sv        = alu_sv_q;
  assign alu_op_prefix = alu_prefix_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_op        = rsp_op_q;
  assign rsp_result    = rsp_result_q;
  assign rsp_err       = rsp_err_q;
  assign rsp_gp        = rsp_gp_q;

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// tb/tb_alu_cmd_issuer.sv - self-checking bench for alu_cmd_issuer
module tb_alu_cmd_issuer;
  localparam int DEPTH = 4;
  localparam int TMO   = 64;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [7:0]  cmd_op = '0;
  logic [31:0] cmd_a = '0, cmd_b = '0;
  logic        cmd_sv = 1'b0, cmd_op_prefix = 1'b0;
  logic        alu_start;
  logic [7:0]  alu_op;
  logic [31:0] alu_a, alu_b;
  logic        alu_sv, alu_op_prefix;
  logic        alu_done = 1'b0;
  logic [63:0] alu_result = '0;
  logic [7:0]  alu_err = '0;
  logic        alu_gp = 1'b0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [7:0]  rsp_op;
  logic [63:0] rsp_result;
  logic [7:0]  rsp_err;
  logic        rsp_gp;
  logic [2:0]  fifo_count;

  always #5 clk = ~clk;

  alu_cmd_issuer #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_sv(cmd_sv), .cmd_op_prefix(cmd_op_prefix),
    .alu_start(alu_start), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_sv(alu_sv), .alu_op_prefix(alu_op_prefix),
    .alu_done(alu_done), .alu_result(alu_result), .alu_err(alu_err), .alu_gp(alu_gp),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_op(rsp_op),
    .rsp_result(rsp_result), .rsp_err(rsp_err), .rsp_gp(rsp_gp),
    .fifo_count(fifo_count)
  );

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- ALU stand-in ----------------
  function automatic logic [63:0] alu_fn(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      8'd1:    return {32'd0, a} + {32'd0, b};
      8'd2:    return {32'd0, a & b};
      8'd3:    return {32'd0, a ^ b};
      8'd4:    return {32'd0, a} * {32'd0, b};
      default: return {a, b};
    endcase
  endfunction

  int alu_lat   = 3;
  bit alu_stall = 1'b0;
  bit spur_en   = 1'b0;
  int wait_cnt  = 0;

  always @(negedge clk) begin
    if (alu_start && !alu_stall) begin
      if (wait_cnt < alu_lat - 1) begin
        wait_cnt++;
        alu_done = 1'b0;
      end else begin
        wait_cnt   = 0;
        alu_done   = 1'b1;
        alu_result = alu_fn(alu_op, alu_a, alu_b);
        alu_err    = (alu_op == 8'd5 && alu_b == 0) ? 8'd1 : 8'd0;
        alu_gp     = (alu_op == 8'd4);
      end
    end else begin
      wait_cnt   = 0;
      alu_done   = spur_en && ($urandom_range(0, 7) == 0);
      alu_result = {$urandom, $urandom};
      alu_err    = 8'($urandom);
      alu_gp     = 1'($urandom);
    end
  end

  // ---------------- reference model (transaction level) ----------------
  typedef struct packed {
    logic [7:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        sv;
    logic        pf;
  } mcmd_t;

  mcmd_t       mq[$];
  bit          m_busy = 0, m_resp = 0;
  int          m_busy_cycles = 0;
  logic        m_start = 0;
  logic [7:0]  m_op = 0;
  logic [31:0] m_a = 0, m_b = 0;
  logic        m_sv = 0, m_pf = 0;
  logic        m_rv = 0;
  logic [7:0]  m_rop = 0, m_rerr = 0;
  logic [63:0] m_rres = 0;
  logic        m_rgp = 0;

  always @(posedge clk) begin
    bit    do_push;
    mcmd_t c;
    if (!reset_n) begin
      mq.delete();
      m_busy = 0; m_resp = 0; m_start = 0;
      m_op = 0; m_a = 0; m_b = 0; m_sv = 0; m_pf = 0;
      m_rv = 0; m_rop = 0; m_rerr = 0; m_rres = 0; m_rgp = 0;
    end else begin
      do_push = cmd_valid && (mq.size() < DEPTH);
      if (m_resp) begin
        if (rsp_ready) begin
          m_resp = 0;
          m_rv   = 0;
        end
      end else if (m_busy) begin
        m_busy_cycles++;
        if (alu_done) begin
          m_rres = alu_result; m_rerr = alu_err; m_rgp = alu_gp; m_rop = m_op;
          m_busy = 0; m_start = 0; m_resp = 1; m_rv = 1;
        end
`ifdef ALU_ISSUE_TIMEOUT_EN
        else if (m_busy_cycles == TMO) begin
          m_rres = 0; m_rerr = 8'hFF; m_rgp = 0; m_rop = m_op;
          m_busy = 0; m_start = 0; m_resp = 1; m_rv = 1;
        end
`endif
      end else if (mq.size() > 0) begin
        c = mq.pop_front();
        if (c.op <= 8'd10) begin
          m_op = c.op; m_a = c.a; m_b = c.b; m_sv = c.sv; m_pf = c.pf;
          m_start = 1; m_busy = 1; m_busy_cycles = 0;
        end else begin
          m_rop = c.op; m_rres = 0; m_rerr = 8'hEE; m_rgp = 0;
          m_resp = 1; m_rv = 1;
        end
      end
      if (do_push) mq.push_back({cmd_op, cmd_a, cmd_b, cmd_sv, cmd_op_prefix});
    end
  end

  always @(posedge clk) begin
    #1;
    chk("cmd_ready", cmd_ready, mq.size() < DEPTH);
    chk("fifo_count", fifo_count, mq.size());
    chk("alu_start", alu_start, m_start);
    chk("alu_op", alu_op, m_op);
    chk("alu_a", alu_a, m_a);
    chk("alu_b", alu_b, m_b);
    chk("alu_sv", alu_sv, m_sv);
    chk("alu_op_prefix", alu_op_prefix, m_pf);
    chk("rsp_valid", rsp_valid, m_rv);
    chk("rsp_op", rsp_op, m_rop);
    chk("rsp_result", rsp_result, m_rres);
    chk("rsp_err", rsp_err, m_rerr);
    chk("rsp_gp", rsp_gp, m_rgp);
  end

  // ---------------- directed helpers ----------------
  task automatic push_cmd(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
    cmd_valid     = 1'b1;
    cmd_op        = op;
    cmd_a         = a;
    cmd_b         = b;
    cmd_sv        = 1'($urandom);
    cmd_op_prefix = 1'($urandom);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int budget);
    bit ok = 0;
    for (int i = 0; i < budget; i++) begin
      if (rsp_valid) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    chk("rsp_wait_budget", ok, 1);
  endtask

  initial begin
    int got[$];
    bit saw_start;

    repeat (2) @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_fifo_count", fifo_count, 0);
    chk("rst_alu_start", alu_start, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    reset_n   = 1'b1;
    rsp_ready = 1'b1;
    @(negedge clk);

    // single add
    alu_lat = 3;
    push_cmd(8'd1, 32'd5, 32'd7);
    chk("add_count_after_accept", fifo_count, 1);
    chk("add_no_start_yet", alu_start, 0);
    @(negedge clk);
    chk("add_start", alu_start, 1);
    chk("add_alu_a", alu_a, 5);
    chk("add_alu_b", alu_b, 7);
    wait_rsp(20);
    chk("add_result", rsp_result, 12);
    chk("add_rsp_op", rsp_op, 1);
    chk("add_rsp_err", rsp_err, 0);
    @(negedge clk);

    // fill and order: op 1 in flight, ops 2..5 fill the FIFO
    alu_stall = 1'b1;
    for (int i = 1; i <= 5; i++) push_cmd(8'(i), 32'(i), 32'(i + 1));
    chk("fill_count", fifo_count, 4);
    chk("fill_ready", cmd_ready, 0);
    push_cmd(8'd6, 32'd1, 32'd1);
    chk("fill_count_after_extra", fifo_count, 4);
    alu_stall = 1'b0;
    alu_lat   = 2;
    for (int i = 0; i < 200 && got.size() < 5; i++) begin
      if (rsp_valid && rsp_ready) got.push_back(int'(rsp_op));
      @(negedge clk);
    end
    chk("order_n", got.size(), 5);
    for (int i = 0; i < got.size(); i++) chk("order_op", got[i], i + 1);
    repeat (3) @(negedge clk);

    // illegal opcode
    saw_start = 0;
    push_cmd(8'd11, 32'hDEAD, 32'hBEEF);
    for (int i = 0; i < 20 && !rsp_valid; i++) begin
      if (alu_start) saw_start = 1;
      @(negedge clk);
    end
    chk("illegal_no_start", saw_start, 0);
    chk("illegal_valid", rsp_valid, 1);
    chk("illegal_err", rsp_err, 8'hEE);
    chk("illegal_result", rsp_result, 0);
    chk("illegal_gp", rsp_gp, 0);
    chk("illegal_op", rsp_op, 11);
    @(negedge clk);

    // back-pressure
    rsp_ready = 1'b0;
    alu_lat   = 2;
    push_cmd(8'd4, 32'd6, 32'd7);
    wait_rsp(20);
    push_cmd(8'd1, 32'd3, 32'd4);
    for (int i = 0; i < 10; i++) begin
      chk("bp_result", rsp_result, 42);
      chk("bp_gp", rsp_gp, 1);
      chk("bp_valid", rsp_valid, 1);
      chk("bp_no_start", alu_start, 0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    wait_rsp(20);
    chk("bp_next_result", rsp_result, 7);
    @(negedge clk);

    // reset mid-op
    alu_stall = 1'b1;
    push_cmd(8'd1, 32'd1, 32'd1);
    push_cmd(8'd2, 32'd2, 32'd2);
    push_cmd(8'd3, 32'd3, 32'd3);
    chk("mid_busy_start", alu_start, 1);
    chk("mid_busy_count", fifo_count, 2);
    reset_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_start", alu_start, 0);
    chk("mid_rst_count", fifo_count, 0);
    chk("mid_rst_valid", rsp_valid, 0);
    reset_n   = 1'b1;
    alu_stall = 1'b0;
    alu_lat   = 1;
    push_cmd(8'd1, 32'd1, 32'd2);
    wait_rsp(20);
    chk("post_rst_result", rsp_result, 3);
    chk("post_rst_op", rsp_op, 1);
    @(negedge clk);

`ifdef ALU_ISSUE_TIMEOUT_EN
    alu_stall = 1'b1;
    push_cmd(8'd2, 32'hF0, 32'h0F);
    wait_rsp(TMO + 20);
    chk("tmo_err", rsp_err, 8'hFF);
    chk("tmo_result", rsp_result, 0);
    chk("tmo_start", alu_start, 0);
    alu_stall = 1'b0;
    @(negedge clk);
`endif

    // randomized traffic
    spur_en = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      cmd_valid     = 1'($urandom_range(0, 1));
      cmd_op        = 8'($urandom_range(0, 12));
      cmd_a         = $urandom;
      cmd_b         = $urandom_range(0, 3) == 0 ? 32'd0 : $urandom;
      cmd_sv        = 1'($urandom);
      cmd_op_prefix = 1'($urandom);
      rsp_ready     = ($urandom_range(0, 3) != 0);
      alu_lat       = $urandom_range(1, 6);
      reset_n       = ($urandom_range(0, 499) != 0);
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    reset_n   = 1'b1;
    rsp_ready = 1'b1;
    spur_en   = 1'b0;
    repeat (100) @(negedge clk);
    chk("drain_count", fifo_count, 0);
    chk("drain_valid", rsp_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
